// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, sign fix-up, held result.
// Divide-by-zero and signed overflow resolve in one cycle without iterating.
module muldiv_seq_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [2:0]        r_func3;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_mcand;
  logic              r_neg;
  logic              r_rem_neg;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_res;

  // MUL counts as signed (its low half is sign-agnostic); MULHSU treats only rs1 as signed.
  assign w_a_signed = func3[2] ? !func3[0] : (func3[1:0] != 2'b11);
  assign w_b_signed = func3[2] ? !func3[0] : !func3[1];
  assign w_a_neg    = w_a_signed & op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & op_b[XLEN-1];
  assign w_abs_a    = w_a_neg ? -op_a : op_a;
  assign w_abs_b    = w_b_neg ? -op_b : op_b;

  assign w_div_zero = (op_b == '0);
  assign w_ovf      = !func3[0] && (op_a == MIN_NEG) && (op_b == '1);
  assign w_fast     = func3[2] & (w_div_zero | w_ovf);
  assign w_fast_res = w_div_zero ? (func3[1] ? op_a : '1)
                                 : (func3[1] ? '0 : op_a);

  // r_lo doubles as multiplier/product-low and dividend/quotient; r_hi as product-high and remainder.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_mcand};

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_quot_fix = r_neg ? -r_lo : r_lo;
  assign w_rem_fix  = r_rem_neg ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    case (r_func3)
      3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quot_fix;
      default:                w_fix_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_func3   <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_func3   <= func3;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_abs_a;
              r_mcand <= w_abs_b;
              r_cnt   <= CNT_W'(XLEN);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_func3[2]) begin
            if (!w_div_diff[XLEN]) begin
              r_hi <= w_div_diff[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
              r_hi <= w_div_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: directed vectors, fast path, random ops
// against a plain-arithmetic model, back-pressure, flush and mid-operation reset.
module tb_muldiv_seq_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_seq_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  // RISC-V M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MIN_NEG;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op; latency is the cycle index (accept cycle = 0) where out_valid is first seen.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit consume, output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    func3 = f; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; func3 = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    res = result;
    $display("[TB] op f=%0d a=%h b=%h result=%h latency=%0d", f, a, b, res, lat);
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  tf [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] ta [8] = '{32'd7, MIN_NEG, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] tb [8] = '{32'hFFFF_FFFD, MIN_NEG, 32'hFFFF_FFFF, 32'd2,
                            32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] te [8] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                            32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 8; i++) begin
      do_op(tf[i], ta[i], tb[i], 1'b1, res, lat);
      n_tests++; if (res !== te[i]) begin n_fail++; $display("FAIL directed_%0d_result got=%h exp=%h", i, res, te[i]); end
      n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL directed_%0d_latency got=%0d exp=34", i, lat); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  tf [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] ta [4] = '{32'h1234, 32'h1234, MIN_NEG, MIN_NEG};
    logic [31:0] tb [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] te [4] = '{32'hFFFF_FFFF, 32'h1234, MIN_NEG, 32'h0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(tf[i], ta[i], tb[i], 1'b1, res, lat);
      n_tests++; if (res !== te[i]) begin n_fail++; $display("FAIL fast_%0d_result got=%h exp=%h", i, res, te[i]); end
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL fast_%0d_latency got=%0d exp=1", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, res, exp_res;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp_res = ref_model(f, a, b);
      exp_lat = ref_latency(f, a, b);
      do_op(f, a, b, 1'b1, res, lat);
      n_tests++; if (res !== exp_res) begin n_fail++; $display("FAIL random_%0d_result f=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, res, exp_res); end
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL random_%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] res;
    int lat;
    do_op(3'b101, 32'd100, 32'd7, 1'b0, res, lat);
    n_tests++; if (res !== 32'd14) begin n_fail++; $display("FAIL bp_result got=%h exp=%h", res, 32'd14); end
    n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL bp_latency got=%0d exp=34", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++; if (result !== 32'd14) begin n_fail++; $display("FAIL bp_hold_%0d_result got=%h exp=%h", i, result, 32'd14); end
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_%0d_flags out_valid=%b in_ready=%b busy=%b exp=1,0,1", i, out_valid, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release in_ready=%b busy=%b out_valid=%b exp=1,0,0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_flush();
    bit seen;
    func3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_calc_idle in_ready=%b busy=%b exp=1,0", in_ready, busy);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_calc_no_valid got=%b exp=0", seen); end
    n_tests++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result_kept got=%h exp=%h", result, 32'd14); end
    $display("[TB] flush during CALC cycle 12");

    func3 = 3'b000; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_accept_blocked busy=%b in_ready=%b exp=0,1", busy, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_accept_no_op got=%b exp=0", seen); end
    $display("[TB] flush coincident with in_valid");
  endtask

  task automatic test_mid_reset();
    logic [31:0] res;
    int lat;
    func3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags in_ready=%b busy=%b out_valid=%b exp=1,0,0", in_ready, busy, out_valid);
    end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL midrst_result got=%h exp=0", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    do_op(3'b000, 32'd3, 32'd5, 1'b1, res, lat);
    n_tests++; if (res !== 32'd15) begin n_fail++; $display("FAIL midrst_mul_result got=%h exp=%h", res, 32'd15); end
    n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL midrst_mul_latency got=%0d exp=34", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fast_path();
    test_random();
    test_back_pressure();
    test_flush();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit, paired with the ALU in the execute stage.
- Accepts one operation at a time over a valid/ready handshake and decodes the M-extension func3 internally.
- Computes one bit per cycle, applies sign correction, and holds the result until the consumer takes it.
- Supports flush for pipeline kills. The execute stage stalls on busy.

Parameters:
- XLEN, 32: operand and result width. Legal values are 32 and 64.
- CNT_W, $clog2(XLEN)+1: iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept. High only in IDLE.
- func3  in  3  M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- flush  in  1  abort any in-flight or pending op.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  operation result.

Behaviour:
- Reset (async on rst_n low; all registers):
  - State goes to IDLE.
  - in_ready=1, busy=0, out_valid=0, result=0.
  - Counter, accumulator and quotient registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - An op is accepted when in_valid & in_ready & !flush.
  - On accept, latch func3. Latch |op_a| and |op_b| for signed ops (MUL counts as signed; MULHSU takes |a| only) and record the result sign.
  - Go to CALC with count=XLEN.
- Fast path (divide ops only), resolved in IDLE on accept:
  - op_b==0: quotient = all ones, remainder = op_a.
  - Signed overflow, op_a = 1<<(XLEN-1) with op_b = all ones (DIV/REM only): quotient = op_a, remainder = 0.
  - Go straight to DONE with result loaded. out_valid rises the cycle after accept.
- CALC, multiply:
  - 2*XLEN shift-add. Each cycle, if the multiplier LSB is set, add the multiplicand into the upper half, then shift right 1.
- CALC, divide:
  - Restoring division. Shift {rem,quot} left 1 and trial-subtract the divisor.
  - If the trial result is non-negative, keep it and set quot LSB=1.
- CALC counter: decrements each cycle. At count==1, go to FIX.
- FIX (1 cycle):
  - If the result sign is negative, take the two's-complement of the 2*XLEN product, or of the quotient for DIV.
  - For REM, the remainder takes the sign of the dividend.
- Result select:
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Load result, go to DONE.
- DONE:
  - out_valid=1 and result is held stable.
  - On out_ready, go to IDLE. in_ready returns the next cycle; there is no same-cycle re-accept.
- Latency, normal path: out_valid is first high XLEN+2 cycles after the accept edge (XLEN CALC cycles plus 1 FIX cycle plus 1 registering cycle; 34 for XLEN=32).
- Flush:
  - In any state, go to IDLE next cycle and drop out_valid. Result is not cleared.
  - Flush takes priority over a simultaneous accept or out_ready.
- result changes only on entry to DONE.
- func3, op_a and op_b are don't-care outside the accept cycle.
- in_valid while busy is ignored. The requester must hold in_valid until in_ready.

Test Plan:
- Reset mid-CALC (rst_n low at cycle 10 of a DIV) -> outputs immediately at reset values; after release, in_ready=1 and a new MUL 3*5 returns 15.
- MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF. In each case out_valid appears exactly 34 cycles after accept.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM 0xFFFFFFF9/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast path: DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. out_valid is high 1 cycle after accept in every case.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0 and busy=1 throughout; out_ready=1 -> IDLE next cycle.
- Flush at CALC cycle 12 -> IDLE next cycle, no out_valid. Flush coincident with in_valid in IDLE -> no accept.
